// File: rtl/act_row_serializer.sv
// act_row_serializer: latches one packed activation row and streams it
// one element per beat with a running write address and row-end marker.
//
// Ports:
//   clk, reset (async, active-high)
//   clear      sync abort of the current row plus address-counter clear
//   in_valid / in_ready / in_data     packed-row handshake
//   out_valid / out_ready / out_data  element handshake
//   out_addr, out_last                write address and row-end marker
//   busy       a row is held
module act_row_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int ARR_INPUTS = 16,
  parameter int ADDR_WIDTH = 10,
  localparam int ARR_WIDTH = DATA_WIDTH * ARR_INPUTS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ARR_WIDTH-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IDXW = (ARR_INPUTS > 1) ? $clog2(ARR_INPUTS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(ARR_INPUTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] row_q [ARR_INPUTS];
  logic                  load;
  logic                  at_last;

  assign at_last = (state_q == SEND) && (idx_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ARR_INPUTS; k++)
        row_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < ARR_INPUTS; k++)
        row_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = addr_q;
    out_last  = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = !reset && !clear;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = row_q[idx_q];
        out_last  = at_last;
        busy      = 1'b1;
        // Accepting on the last beat gives zero-bubble row chaining.
        in_ready  = out_ready && at_last && !clear;
      end
      default: ;
    endcase

    if (clear) begin
      // Any in-flight beat still completes on the bus this cycle.
      state_d = IDLE;
      idx_d   = '0;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (at_last) begin
              idx_d = '0;
              if (in_valid)
                load = 1'b1;
              else
                state_d = IDLE;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_act_row_serializer.sv
// tb_act_row_serializer: directed bench for act_row_serializer with
// four 16-bit elements per row and a 3-bit address counter.
module tb_act_row_serializer;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW*N-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  act_row_serializer #(
    .DATA_WIDTH(DW),
    .ARR_INPUTS(N),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 3'd0 ||
        out_data !== 16'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b b=%b a=%0d d=%h l=%b, need all 0",
               out_valid, busy, out_addr, out_data, out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
  endtask

  task automatic test_single_row();
    logic [DW-1:0] exp_d [N] = '{16'h1, 16'h2, 16'h3, 16'h4};
    @(negedge clk);
    in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: in_ready %b need 1", in_ready);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = '1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] ||
          out_addr !== AW'(i) || out_last !== (i == N - 1)) begin
        errors++;
        $display("FAIL single_beat%0d: v=%b d=%h a=%0d l=%b need 1 %h %0d %b",
                 i, out_valid, out_data, out_addr, out_last,
                 exp_d[i], i, (i == N - 1));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: v=%b b=%b need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [8] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                 16'h0010, 16'h0011, 16'hFFFF, 16'h8000};
    do_clear();
    in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0)
        in_data = {16'h8000, 16'hFFFF, 16'h0011, 16'h0010};
      if (i == 7)
        in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] ||
          out_addr !== AW'(i) || out_last !== (i % 4 == 3) ||
          in_ready !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_beat%0d: v=%b d=%h a=%0d l=%b r=%b need 1 %h %0d %b %b",
                 i, out_valid, out_data, out_addr, out_last, in_ready,
                 exp_d[i], i, (i % 4 == 3), (i % 4 == 3));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: out_valid %b need 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic          rdy [7]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] exp_d [7] = '{16'h1, 16'h2, 16'h2, 16'h2, 16'h2, 16'h3, 16'h4};
    logic [AW-1:0] exp_a [7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
    do_clear();
    in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_valid = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = rdy[j];
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[j] ||
          out_addr !== exp_a[j] || out_last !== (j == 6)) begin
        errors++;
        $display("FAIL stall_step%0d: v=%b d=%h a=%0d l=%b need 1 %h %0d %b",
                 j, out_valid, out_data, out_addr, out_last,
                 exp_d[j], exp_a[j], (j == 6));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: out_valid %b need 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                  3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    do_clear();
    out_ready = 1'b1;
    in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3)  in_data = {16'd8, 16'd7, 16'd6, 16'd5};
      if (i == 7)  in_data = {16'd12, 16'd11, 16'd10, 16'd9};
      if (i == 11) in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_addr !== exp_a[i] ||
          out_data !== DW'(i + 1)) begin
        errors++;
        $display("FAIL wrap_beat%0d: v=%b a=%0d d=%0d need 1 %0d %0d",
                 i, out_valid, out_addr, out_data, exp_a[i], i + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    // address counter sits at 4 after the wrap test
    in_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 16'h1 || out_addr !== 3'd4) begin
      errors++;
      $display("FAIL clear_pre: d=%h a=%0d need 1 4", out_data, out_addr);
    end
    @(negedge clk);
    clear = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h2 || out_addr !== 3'd5) begin
      errors++;
      $display("FAIL clear_beat: v=%b d=%h a=%0d need 1 2 5",
               out_valid, out_data, out_addr);
    end
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 3'd0) begin
      errors++;
      $display("FAIL clear_after: v=%b b=%b a=%0d need 0 0 0",
               out_valid, busy, out_addr);
    end
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks: in_ready %b need 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_no_accept: v=%b r=%b need 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1 || out_addr !== 3'd0) begin
      errors++;
      $display("FAIL clear_restart: v=%b d=%h a=%0d need 1 1 0",
               out_valid, out_data, out_addr);
    end
  endtask

  task automatic test_async_reset();
    // continues the row left in flight by test_clear
    @(negedge clk);
    #1;
    checks++;
    if (out_data !== 16'h2 || out_addr !== 3'd1) begin
      errors++;
      $display("FAIL areset_pre: d=%h a=%0d need 2 1", out_data, out_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== 3'd0) begin
      errors++;
      $display("FAIL areset_now: v=%b b=%b a=%0d need 0 0 0",
               out_valid, busy, out_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_after: r=%b v=%b need 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_row_serializer.md
Name: act_row_serializer

Overview:
- Consumer end of the activation array's packed output bus: captures one packed row of ARR_INPUTS activated values and streams them out one element per beat over a valid/ready interface to the activation buffer writer.
- Generates a running write address per element and a row-end marker.
- Sits between the ReLU array output and the on-chip activation memory.

Parameters:
- DATA_WIDTH, 16, bits per element.
- ARR_INPUTS, 16, elements per packed row.
- ADDR_WIDTH, 10, width of the output address counter.
- Derived localparam ARR_WIDTH = DATA_WIDTH*ARR_INPUTS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous address-counter clear, also aborts the current row.
- in_valid  input  1  packed row available.
- in_ready  output  1  serializer can accept a row this cycle.
- in_data  input  ARR_WIDTH  packed row; element k is in_data[k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  out_data/out_addr valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  current element, passed through unmodified.
- out_addr  output  ADDR_WIDTH  write address of the current element.
- out_last  output  1  current beat is element ARR_INPUTS-1 of the row.
- busy  output  1  a row is held (state SEND).

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (reset).
- Reset (async assert; deassert takes effect at the next clk edge):
  - state=IDLE, idx=0, addr=0, row register=0.
  - out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, in_ready=1 once out of reset.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid, latch in_data, set idx=0, go to SEND.
  - SEND: out_valid=1, out_data=row[idx], out_addr=addr, out_last=(idx==ARR_INPUTS-1).
    - A beat transfers on out_valid&&out_ready. Each transfer increments idx and addr.
    - Transfer of the last element: if in_valid, latch the next row, set idx=0 and stay in SEND (zero-bubble back-to-back). Otherwise go to IDLE.
- in_ready in SEND = out_ready && out_last (combinational). This permits back-to-back rows.
- A row is accepted only on in_valid&&in_ready. in_data is sampled once, so upstream may change in_data after acceptance.
- Latency: first element is valid on the cycle after row acceptance. A full row under constant out_ready takes exactly ARR_INPUTS beats. Sustained throughput is 1 element/cycle.
- Stall: while out_valid && !out_ready, out_data, out_addr and out_last hold stable. out_valid is never withdrawn without a transfer.
- Address: addr is modulo 2^ADDR_WIDTH and wraps silently from 2^ADDR_WIDTH-1 to 0. It persists across rows and returns to 0 only on reset or clear.
- clear (synchronous, highest priority after reset):
  - addr=0, idx=0, state=IDLE, out_valid=0 next cycle; any partially sent row is dropped.
  - in_ready is forced to 0 during the clear cycle, so no row is accepted in that cycle.
  - clear coincident with a transfer: the transfer completes on the bus, but counters still clear.
- out_data carries signed values unmodified; no arithmetic on data.
- ARR_INPUTS==1: every beat has out_last=1 and back-to-back rows stream at 1 row/cycle.

Test Plan:
- Reset, then ARR_INPUTS=4, DATA_WIDTH=16, in_data={16'h0004,16'h0003,16'h0002,16'h0001} with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles starting the cycle after acceptance; out_addr 0..3; out_last only on 4.
- Two rows presented back-to-back with out_ready=1 -> 8 consecutive beats with no bubble; out_addr 0..7; in_ready high only on the out_last beats.
- out_ready low for 3 cycles during element 2 -> out_data=2 and out_addr=1 held stable with out_valid=1; the stream resumes with no loss or duplication.
- ADDR_WIDTH=3, three rows of 4 -> out_addr sequence 0..7,0..3 (wrap after 7).
- Assert clear mid-row at element 2 -> out_valid=0 next cycle; the next row starts at out_addr=0 with element 1.
- Assert reset asynchronously mid-row (between clock edges) -> out_valid, busy and out_addr go to 0 immediately; in_ready=1 after deassertion.
